// File: rtl/sram_arb.sv
// sram_arb: two-client arbiter in front of one two-port SRAM (separate read/write ports).
// Grants are combinational from the requests and registered arbitration state. Read
// data comes back one cycle after the grant, tagged to the requesting client.
// Build option: define SRAM_ARB_BURST_EN for burst-ownership arbitration (IDLE/OWN0/OWN1
// FSM plus an 8-bit burst counter). Without it, arbitration is per-cycle round-robin.
module sram_arb #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  wr0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_ce,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The burst counter is 8 bits wide, so the burst length must fit in it.
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_burst_len_check
        $error("sram_arb: BURST_LEN must be within 1..255");
    end

    logic g0;      // arbitration winner before reset gating
    logic g1;
    logic last;    // last granted client: 0 or 1

`ifdef SRAM_ARB_BURST_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // Ownership state and burst counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Burst arbitration: the owner keeps priority until it stops requesting or has used
    // BURST_LEN grants while the other client waits; the counter saturates when nobody waits.
    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OWN0: begin
                if (req0 && (cnt < BURST_MAX || !req1)) begin
                    g0 = 1'b1;
                    if (cnt < BURST_MAX) cnt_nxt = cnt + 8'd1;
                end else if (req1) begin
                    g1        = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = 8'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            OWN1: begin
                if (req1 && (cnt < BURST_MAX || !req0)) begin
                    g1 = 1'b1;
                    if (cnt < BURST_MAX) cnt_nxt = cnt + 8'd1;
                end else if (req0) begin
                    g0        = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = 8'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                // From IDLE a conflict is broken by the last-granted pointer.
                if (req0 && (!req1 || last)) begin
                    g0        = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = 8'd1;
                end else if (req1) begin
                    g1        = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = 8'd1;
                end
            end
        endcase
    end
`else
    // Per-cycle round-robin: on a conflict the client not granted last wins.
    always_comb begin
        g0 = req0 && (!req1 || last);
        g1 = req1 && !g0;
    end
`endif

    // Last-granted pointer; reset favours client 0 in the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (g0) begin
            last <= 1'b0;
        end else if (g1) begin
            last <= 1'b1;
        end
    end

    // Grants are forced low while reset is held, independent of the clock.
    always_comb begin
        gnt0 = g0 && !rst;
        gnt1 = g1 && !rst;
    end

    // Memory command mux; all outputs are zero when nothing is granted.
    always_comb begin
        mem_ce    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (gnt0 || gnt1) begin
            mem_ce = 1'b1;
            if (gnt0 ? wr0 : wr1) begin
                mem_we    = 1'b1;
                mem_waddr = gnt0 ? addr0 : addr1;
                mem_wdata = gnt0 ? wdata0 : wdata1;
            end else begin
                mem_re    = 1'b1;
                mem_raddr = gnt0 ? addr0 : addr1;
            end
        end
    end

    // Read-return tags, one cycle behind the grant; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !wr0;
            rvalid1 <= gnt1 && !wr1;
        end
    end

    // Steer the shared SRAM read data to the client that issued the read.
    always_comb begin
        rdata0 = rvalid0 ? mem_rdata : '0;
        rdata1 = rvalid1 ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed bench for sram_arb with a behavioural two-port SRAM model.
// Define SRAM_ARB_BURST_EN for both bench and RTL to exercise burst arbitration.
module tb_sram_arb;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, wr0, req1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, rvalid0, gnt1, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_ce, mem_re, mem_we;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:15];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BURST_LEN (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .wr0      (wr0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .wr1      (wr1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .mem_ce   (mem_ce),
        .mem_re   (mem_re),
        .mem_raddr(mem_raddr),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Two-port SRAM: write port and registered read port.
    always @(posedge clk) begin
        if (mem_ce && mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_ce && mem_re) mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:9] exp_g0;
        logic [1:0] e_rv;
        logic [15:0] e_rd;
`ifdef SRAM_ARB_BURST_EN
        exp_g0 = 10'b1111000011;
`else
        exp_g0 = 10'b1010101010;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);

        // Reset held with both clients requesting: everything forced low.
        rst = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h5A;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd2; wdata1 = 8'h00;
        @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_mem", {mem_ce, mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata}, 0);
        chk("rst_rv", {rvalid0, rvalid1, rdata0, rdata1}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_in();

        // Idle: no requests.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_gnt", {gnt0, gnt1}, 2'b00);
            chk("idle_mem", {mem_ce, mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata}, 0);
            chk("idle_rv", {rvalid0, rvalid1, rdata0, rdata1}, 0);
            next_cyc();
        end

        // Client 0 writes addr 3 = A5, then reads it back.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
        @(negedge clk);
        chk("wr_gnt", {gnt0, gnt1}, 2'b10);
        chk("wr_ctl", {mem_ce, mem_we, mem_re}, 3'b110);
        chk("wr_addr_data", {mem_waddr, mem_wdata, mem_raddr}, {4'd3, 8'hA5, 4'd0});
        next_cyc();
        wr0 = 1'b0;
        @(negedge clk);
        chk("rd_gnt", {gnt0, gnt1}, 2'b10);
        chk("rd_ctl", {mem_ce, mem_we, mem_re}, 3'b101);
        chk("rd_addr", {mem_raddr, mem_waddr, mem_wdata}, {4'd3, 4'd0, 8'h00});
        chk("rd_no_rv_for_wr", rvalid0, 1'b0);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("wr_rd_rv0", {rvalid0, rdata0}, {1'b1, 8'hA5});
        chk("wr_rd_rv1", {rvalid1, rdata1}, 0);
        next_cyc();
        @(negedge clk);
        chk("rv0_one_cycle", {rvalid0, rdata0}, 0);
        next_cyc();

        // Only client 1 requests for 6 cycles (reads of addr 5).
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("single_gnt", {gnt0, gnt1}, 2'b01);
            chk("single_ce", {mem_ce, mem_re}, 2'b11);
            chk("single_rv1", {rvalid1, rdata1}, (i == 0) ? 9'h000 : {1'b1, 8'h35});
            next_cyc();
        end
        idle_in();
        @(negedge clk);
        chk("single_last_rv1", {rvalid1, rdata1}, {1'b1, 8'h35});
        next_cyc();

        // Both clients request reads continuously (addr 1 and addr 2).
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cf_gnt", {gnt0, gnt1}, {exp_g0[i], ~exp_g0[i]});
            if (i == 0) begin
                e_rv = 2'b00;
                e_rd = 16'h0000;
            end else begin
                e_rv = {exp_g0[i-1], ~exp_g0[i-1]};
                e_rd = exp_g0[i-1] ? 16'h3100 : 16'h0032;
            end
            chk("cf_rv", {rvalid0, rvalid1}, e_rv);
            chk("cf_rd", {rdata0, rdata1}, e_rd);
            next_cyc();
        end
        idle_in();
        @(negedge clk);
        chk("cf_last_rv", {rvalid0, rvalid1}, {exp_g0[9], ~exp_g0[9]});
        next_cyc();

        // Reset pulsed across the edge that would return client 0's read.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd1;
        @(negedge clk);
        chk("rr_gnt", {gnt0, gnt1}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rr_gnt_forced", {gnt0, gnt1, mem_ce, mem_re}, 4'b0000);
        @(posedge clk);
        #1;
        chk("rr_rv_in_rst", {rvalid0, rdata0}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_in();
        next_cyc();
        chk("rr_rv_after", {rvalid0, rvalid1}, 2'b00);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd2;
        @(negedge clk);
        chk("rr_first_cf", {gnt0, gnt1}, 2'b10);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("rr_cf_rv", {rvalid0, rdata0, rvalid1}, {1'b1, 8'h31, 1'b0});
        next_cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
- REQ-001 SHALL take parameter ADDR_WIDTH, default 4: address width of each client and of the memory port.
- REQ-002 SHALL take parameter DATA_WIDTH, default 8: data width of each client and of the memory port.
- REQ-003 SHALL take parameter BURST_LEN, default 4: maximum consecutive grants to one client while the other waits; legal range 1..255.
- REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
- REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
- REQ-006 SHALL have, for each client n in {0,1}, the ports below.
  - reqn  input  1: request.
  - wrn  input  1: 1 = write, 0 = read.
  - addrn  input  ADDR_WIDTH: address.
  - wdatan  input  DATA_WIDTH: write data.
- REQ-007 SHALL have, for each client n in {0,1}, the ports below.
  - gntn  output  1: request accepted this cycle.
  - rvalidn  output  1: read data valid.
  - rdatan  output  DATA_WIDTH: read data.
- REQ-008 SHALL have the memory-side outputs below, driving one two-port SRAM.
  - mem_ce  output  1.
  - mem_re  output  1.
  - mem_raddr  output  ADDR_WIDTH.
  - mem_we  output  1.
  - mem_waddr  output  ADDR_WIDTH.
  - mem_wdata  output  DATA_WIDTH.
- REQ-009 SHALL have port mem_rdata  input  DATA_WIDTH: SRAM read data, registered one cycle after mem_re.

Function
- REQ-010 SHALL grant at most one client per cycle; gntn is combinational from reqn and registered state, and is asserted in the same cycle the command is issued.
- REQ-011 A client SHALL hold reqn, wrn, addrn and wdatan stable until it samples gntn=1; a request is consumed on every cycle with gntn=1.
- REQ-012 When only one client requests, that client SHALL be granted.
- REQ-013 When both clients request, the client not granted last SHALL be granted (round-robin). A last-granted pointer updates on every grant.
- REQ-014 On a granted write, the block SHALL drive, in the same cycle:
  - mem_ce=1, mem_we=1, mem_re=0;
  - mem_waddr=addrn, mem_wdata=wdatan.
- REQ-015 On a granted read, the block SHALL drive, in the same cycle:
  - mem_ce=1, mem_re=1, mem_we=0;
  - mem_raddr=addrn.
- REQ-016 With no grant, mem_ce, mem_re and mem_we SHALL be 0. Address and data outputs SHALL be 0 (no X propagation).
- REQ-017 rvalidn SHALL assert exactly one cycle after a granted read by client n, for one cycle. rdatan SHALL equal mem_rdata while rvalidn=1 and 0 otherwise.
- REQ-018 Back-to-back reads SHALL be supported, one per cycle, with no bubble. The rvalid tag pipeline depth is 1.
- REQ-019 A granted write followed next cycle by a granted read of the same address SHALL return the new data. Write-then-read ordering is preserved by the SRAM.

Reset
- REQ-020 While rst=1, the block SHALL force the following, asynchronously:
  - gnt0, gnt1, rvalid0, rvalid1 = 0;
  - rdata0, rdata1 = 0;
  - all mem_* outputs = 0.
- REQ-021 Reset SHALL set the last-granted pointer to client 1, so client 0 wins the first conflict. It SHALL set the FSM to IDLE and the burst counter to 0.
- REQ-022 Reset asserted while a read is in flight SHALL discard it; no rvalid is produced after rst deasserts.

Configuration
- REQ-023 Macro SRAM_ARB_BURST_EN SHALL select between two arbitration modes.
  - Defined: an FSM with states IDLE, OWN0, OWN1 and an 8-bit burst counter.
  - IDLE -> OWNn on a grant to n; the counter loads 1.
  - In OWNn, n keeps priority while reqn=1 and counter<BURST_LEN; the counter increments per grant.
  - At counter=BURST_LEN with the other client requesting, ownership moves to the other client and the counter loads 1.
  - If reqn=0, the other client is granted if it requests (switch), else the FSM returns to IDLE.
  - At counter=BURST_LEN with no other request, n continues and the counter saturates.
- REQ-024 Without SRAM_ARB_BURST_EN, the block SHALL use pure per-cycle round-robin (REQ-013), with no FSM or counter.

Verification
- REQ-025 Write then read. Client 0 writes addr 3 = 0xA5, then reads addr 3 next cycle -> gnt0 both cycles; mem_we then mem_re; rvalid0=1 with rdata0=0xA5 one cycle after the read.
- REQ-026 Conflict, macro off. Both clients hold reads to addr 1 and 2 for 4 cycles -> grants 0,1,0,1; rvalid pattern is the same, delayed one cycle.
- REQ-027 Burst, macro on, BURST_LEN=4. Both clients request continuously for 10 cycles -> grants 0,0,0,0,1,1,1,1,0,0.
- REQ-028 Single requester. Only client 1 requests for 6 cycles -> gnt1=1 every cycle, gnt0=0, mem_ce=1 throughout.
- REQ-029 Reset mid-read. Client 0 read granted, rst pulsed before the next edge -> rvalid0 stays 0; after release, the first conflict is granted to client 0.
- REQ-030 Idle. No requests -> mem_ce=mem_re=mem_we=0 and all addr/data outputs 0 every cycle.
